// File: rtl/tinytpu_pkg.sv
// Shared TPU constants and the result collector state encoding.
package tinytpu_pkg;
    localparam int TPU_D_W     = 8;
    localparam int TPU_N       = 2;
    localparam int RW          = 2 * TPU_D_W;
    localparam int FRAME_WORDS = TPU_N * TPU_N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } coll_state_e;
endpackage

// File: rtl/serial_word_deser.sv
// LSB-first serial-to-parallel converter: drops each bit into its slot and
// strobes the assembled word on the cycle its final bit arrives.
module serial_word_deser
    import tinytpu_pkg::*;
#(
    parameter int W = RW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         shift_en,
    input  logic         din,
    output logic [W-1:0] word,
    output logic         word_strobe
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          last_bit;

    assign last_bit = (bit_cnt_q == CW'(W - 1));

    // word already contains the incoming bit so the strobe cycle can store it directly
    always_comb begin
        word            = shreg_q;
        word[bit_cnt_q] = din;
        word_strobe     = shift_en && last_bit;
        shreg_d         = shreg_q;
        bit_cnt_d       = bit_cnt_q;
        if (clear) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
        end else if (shift_en) begin
            shreg_d   = word;
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end
endmodule

// File: rtl/result_collector.sv
// Collects one serialized N*N result frame into a local buffer and replays
// it as a valid/ready word stream, flagging short frames and overruns.
module result_collector
    import tinytpu_pkg::*;
#(
    parameter int D_W = TPU_D_W,
    parameter int N   = TPU_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             data_out_z,
    input  logic             tx_ready,
    output logic [2*D_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_done,
    output logic             frame_err,
    output logic             overrun
);
    localparam int RWL = 2 * D_W;
    localparam int FW  = N * N;
    localparam int AW  = (FW > 1) ? $clog2(FW) : 1;
    localparam int PW  = $clog2(FW + 1);

    coll_state_e    state_q, state_d;
    logic [AW-1:0]  word_cnt_q, word_cnt_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [RWL-1:0] out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           frame_done_q, frame_done_d;
    logic           frame_err_q, frame_err_d;
    logic           overrun_q, overrun_d;
    logic           tx_prev_q;

    logic [RWL-1:0] frame_mem [FW];
    logic [AW-1:0]  rd_idx;
    logic           mem_we;
    logic           rise;
    logic           deser_shift;
    logic           deser_clear;
    logic [RWL-1:0] deser_word;
    logic           word_strobe;

    // Frames only start on a rising tx_ready, so trailing bits of a finished
    // frame can never be mistaken for the start of the next one.
    assign rise        = tx_ready && !tx_prev_q;
    assign deser_shift = !init && tx_ready && ((state_q == RECV) || rise);
    assign deser_clear = init || ((state_q == RECV) && !tx_ready);
    assign rd_idx      = rd_ptr_q[AW-1:0];

    serial_word_deser #(.W(RWL)) u_deser (
        .clk         (clk),
        .rst_n       (rst),
        .clear       (deser_clear),
        .shift_en    (deser_shift),
        .din         (data_out_z),
        .word        (deser_word),
        .word_strobe (word_strobe)
    );

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        rd_ptr_d     = rd_ptr_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        frame_done_d = frame_done_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        mem_we       = 1'b0;
        if (init) begin
            state_d      = IDLE;
            word_cnt_d   = '0;
            rd_ptr_d     = '0;
            out_data_d   = '0;
            out_valid_d  = 1'b0;
            frame_done_d = 1'b0;
            frame_err_d  = 1'b0;
            overrun_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d    = RECV;
                        word_cnt_d = '0;
                    end
                end
                RECV: begin
                    if (!tx_ready) begin
                        frame_err_d = 1'b1;
                        word_cnt_d  = '0;
                        state_d     = IDLE;
                    end else if (word_strobe) begin
                        mem_we = 1'b1;
                        if (word_cnt_q == AW'(FW - 1)) begin
                            word_cnt_d   = '0;
                            rd_ptr_d     = '0;
                            frame_done_d = 1'b1;
                            state_d      = DONE;
                        end else begin
                            word_cnt_d = word_cnt_q + AW'(1);
                        end
                    end
                end
                DONE: begin
                    if (rise) begin
                        overrun_d    = 1'b1;
                        out_valid_d  = 1'b0;
                        frame_done_d = 1'b0;
                        rd_ptr_d     = '0;
                        word_cnt_d   = '0;
                        state_d      = RECV;
                    end else if (!out_valid_q || out_ready) begin
                        if (rd_ptr_q != PW'(FW)) begin
                            out_data_d  = frame_mem[rd_idx];
                            out_valid_d = 1'b1;
                            rd_ptr_d    = rd_ptr_q + PW'(1);
                        end else begin
                            out_valid_d  = 1'b0;
                            frame_done_d = 1'b0;
                            rd_ptr_d     = '0;
                            state_d      = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            frame_mem[word_cnt_q] <= deser_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            word_cnt_q   <= '0;
            rd_ptr_q     <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            tx_prev_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            tx_prev_q    <= tx_ready;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector with D_W=8, N=2 (four 16-bit words per frame).
module tb_result_collector;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init = 1'b0;
    logic        data_out_z = 1'b0;
    logic        tx_ready = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        frame_done;
    logic        frame_err;
    logic        overrun;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] got [4];
    int          got_n;

    always #5 clk = ~clk;

    result_collector #(.D_W(8), .N(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .init       (init),
        .data_out_z (data_out_z),
        .tx_ready   (tx_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        tx_ready   = 1'b1;
        data_out_z = b;
        tick();
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 0; i < 16; i++) send_bit(w[i]);
    endtask

    task automatic send_frame(input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3);
        send_word(w0);
        send_word(w1);
        send_word(w2);
        send_word(w3);
    endtask

    // Drains with out_ready=1; tx_ready is kept high with junk bits for 'extra' cycles.
    task automatic collect(input int extra);
        got_n     = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c < extra) begin
                tx_ready   = 1'b1;
                data_out_z = 1'($urandom_range(1, 0));
            end else begin
                tx_ready = 1'b0;
            end
            if (c >= extra && got_n == 4) break;
            if (out_valid && got_n < 4) begin
                got[got_n] = out_data;
                $display("  word %0d = %h", got_n, out_data);
                got_n++;
            end
            tick();
        end
        tx_ready  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick(); tick();
        checks++; if (out_valid !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("FAIL reset_held valid/done got=%b%b exp=00", out_valid, frame_done); end
        rst = 1'b1;
        tick();
        checks++; if (out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL reset_flags got err=%b ovr=%b exp=0 0", frame_err, overrun); end
        $display("reset done");
    endtask

    task automatic test_full_frame();
        logic [15:0] e [4] = '{16'h0001, 16'h1234, 16'hBEEF, 16'h8000};
        send_frame(e[0], e[1], e[2], e[3]);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_valid_early got=%b exp=0", out_valid); end
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL full_frame_done got=%b exp=1", frame_done); end
        tx_ready = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL full_valid_latency got=%b exp=1", out_valid); end
        checks++; if (out_data !== e[0]) begin failures++; $display("FAIL full_first_word got=%h exp=%h", out_data, e[0]); end
        collect(0);
        checks++; if (got_n !== 4) begin failures++; $display("FAIL full_word_count got=%0d exp=4", got_n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got[i] !== e[i]) begin failures++; $display("FAIL full_word%0d got=%h exp=%h", i, got[i], e[i]); end
        end
        checks++; if (out_valid !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("FAIL full_after_drain valid/done got=%b%b exp=00", out_valid, frame_done); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL full_flags got err=%b ovr=%b exp=0 0", frame_err, overrun); end
        $display("full frame done");
    endtask

    task automatic test_backpressure();
        logic [15:0] e [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int          idx = 0;
        send_frame(e[0], e[1], e[2], e[3]);
        tx_ready = 1'b0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            out_ready = pat[c % 4];
            if (out_valid) begin
                checks++; if (out_data !== e[idx]) begin failures++; $display("FAIL bp_word%0d cycle %0d got=%h exp=%h", idx, c, out_data, e[idx]); end
                if (out_ready) begin
                    $display("  bp accept word %0d = %h", idx, out_data);
                    idx++;
                end
            end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (idx !== 4) begin failures++; $display("FAIL bp_accepted got=%0d exp=4", idx); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_extra_word got=%b exp=0", out_valid); end
        $display("backpressure done");
    endtask

    task automatic test_extra_bits();
        logic [15:0] e [4] = '{16'hCAFE, 16'h0F0F, 16'h7001, 16'hFFFF};
        send_frame(e[0], e[1], e[2], e[3]);
        collect(8);
        checks++; if (got_n !== 4) begin failures++; $display("FAIL extra_word_count got=%0d exp=4", got_n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got[i] !== e[i]) begin failures++; $display("FAIL extra_word%0d got=%h exp=%h", i, got[i], e[i]); end
        end
        tick(); tick(); tick();
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL extra_frame_err got=%b exp=0", frame_err); end
        checks++; if (out_valid !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("FAIL extra_idle valid/done got=%b%b exp=00", out_valid, frame_done); end
        $display("extra bits done");
    endtask

    task automatic test_truncated();
        logic [15:0] e [4] = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
        int          seen = 0;
        for (int i = 0; i < 20; i++) send_bit(i[0]);
        tx_ready = 1'b0;
        tick();
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL trunc_frame_err got=%b exp=1", frame_err); end
        for (int c = 0; c < 6; c++) begin
            if (out_valid) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL trunc_valid_cycles got=%0d exp=0", seen); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL trunc_frame_done got=%b exp=0", frame_done); end
        send_frame(e[0], e[1], e[2], e[3]);
        collect(0);
        checks++; if (got_n !== 4) begin failures++; $display("FAIL trunc_next_count got=%0d exp=4", got_n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got[i] !== e[i]) begin failures++; $display("FAIL trunc_next_word%0d got=%h exp=%h", i, got[i], e[i]); end
        end
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL trunc_err_sticky got=%b exp=1", frame_err); end
        $display("truncated frame done");
    endtask

    task automatic test_overrun();
        send_frame(16'h0011, 16'h0022, 16'h0033, 16'h0044);
        tx_ready  = 1'b0;
        out_ready = 1'b0;
        tick();
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_before got=%b exp=0", overrun); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_data !== 16'h0022) begin failures++; $display("FAIL ovr_second_word got=%h exp=0022", out_data); end
        tick();
        send_frame(16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        collect(0);
        checks++; if (got_n !== 4) begin failures++; $display("FAIL ovr_word_count got=%0d exp=4", got_n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got[i] !== 16'hAAAA) begin failures++; $display("FAIL ovr_word%0d got=%h exp=aaaa", i, got[i]); end
        end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL ovr_done_after got=%b exp=0", frame_done); end
        $display("overrun done");
    endtask

    task automatic test_init_mid();
        logic [15:0] e [4] = '{16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0};
        for (int i = 0; i < 30; i++) send_bit(i[1]);
        tx_ready   = 1'b1;
        data_out_z = 1'b1;
        init       = 1'b1;
        tick();
        init     = 1'b0;
        tx_ready = 1'b0;
        checks++; if (out_data !== 16'h0) begin failures++; $display("FAIL init_out_data got=%h exp=0000", out_data); end
        checks++; if (out_valid !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("FAIL init_valid_done got=%b%b exp=00", out_valid, frame_done); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL init_flags got err=%b ovr=%b exp=0 0", frame_err, overrun); end
        tick();
        send_frame(e[0], e[1], e[2], e[3]);
        collect(0);
        checks++; if (got_n !== 4) begin failures++; $display("FAIL init_next_count got=%0d exp=4", got_n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got[i] !== e[i]) begin failures++; $display("FAIL init_next_word%0d got=%h exp=%h", i, got[i], e[i]); end
        end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL init_next_err got=%b exp=0", frame_err); end
        $display("init mid-frame done");
    endtask

    task automatic test_rst_mid();
        logic [15:0] e [4] = '{16'h00FF, 16'hFF00, 16'h5A5A, 16'hA5A5};
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        tx_ready = 1'b0;
        tick();
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL rst_pre_err got=%b exp=1", frame_err); end
        for (int i = 0; i < 30; i++) send_bit(i[0]);
        tx_ready   = 1'b1;
        data_out_z = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (out_data !== 16'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0000", out_data); end
        checks++; if (out_valid !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("FAIL rst_valid_done got=%b%b exp=00", out_valid, frame_done); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL rst_flags got err=%b ovr=%b exp=0 0", frame_err, overrun); end
        tx_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        send_frame(e[0], e[1], e[2], e[3]);
        collect(0);
        checks++; if (got_n !== 4) begin failures++; $display("FAIL rst_next_count got=%0d exp=4", got_n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got[i] !== e[i]) begin failures++; $display("FAIL rst_next_word%0d got=%h exp=%h", i, got[i], e[i]); end
        end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL rst_next_flags got err=%b ovr=%b exp=0 0", frame_err, overrun); end
        $display("async reset mid-frame done");
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_extra_bits();
        test_truncated();
        test_overrun();
        test_init_mid();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Sits directly downstream of the TPU output serializer.
- Deserializes the data_out_z / tx_ready bit stream into 2*D_W-bit result words and captures one full N*N result frame in a local buffer.
- Presents the frame to the host word by word over a valid/ready stream.
- Flags truncated frames and frames that overwrite unread results.

Parameters:
D_W, 8, operand width; each result word is 2*D_W bits
N, 2, systolic array dimension; one frame holds N*N words, row-major

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
init  input  1  synchronous soft clear, same pulse that drives the core
data_out_z  input  1  serial result bit from the output serializer
tx_ready  input  1  high while serial result bits are valid
out_data  output  2*D_W  result word at the stream head
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high
frame_done  output  1  a complete frame is buffered and not yet fully drained
frame_err  output  1  sticky; the last frame ended mid-word or short
overrun  output  1  sticky; a new frame started before the previous frame was drained

Behaviour:
- Upstream contract: while tx_ready=1, one data_out_z bit per clk, LSB first. Words of 2*D_W bits are contiguous, N*N words per frame, row-major (z[0][0], z[0][1], ...). tx_ready low between frames.
- Reset (rst=0, async): state=IDLE, all counters 0. out_data=0, out_valid=0, frame_done=0, frame_err=0, overrun=0. Buffer contents don't care.
- init=1 (sync, highest priority after rst): same clear as reset. Any in-flight frame is discarded.
- FSM states:
  - IDLE: wait for tx_ready=1. On the first cycle with tx_ready=1, capture bit 0 and go to RECV. If frame_done=1 at that moment: set overrun, drop the unread words, reset the read pointer.
  - RECV: shift data_out_z into bit position bit_cnt; bit_cnt counts 0..2*D_W-1.
    - On bit 2*D_W-1: write the word to buf[word_cnt]; word_cnt++.
    - When word N*N-1 is written: go to DONE.
    - tx_ready falls before that: set frame_err, discard the partial frame, go to IDLE, frame_done stays 0.
  - DONE: frame_done=1, read pointer=0, out_valid=1 next cycle. Each accepted handshake advances the pointer.
    - After word N*N-1 is accepted: out_valid=0, frame_done=0, go to IDLE.
    - Bits arriving while tx_ready is still high after a full frame are ignored until tx_ready falls; frame_err is not set.
    - A new tx_ready rise while still draining: overrun=1, abort the drain, go to RECV capturing that bit.
- Latency: out_valid rises 1 cycle after the last bit of word N*N-1 is sampled.
- out_data is registered and holds stable while out_valid=1 and out_ready=0.
- No arithmetic on data; width is exactly 2*D_W. Counter widths are $clog2 sized, wrap-free (explicit terminal compare).
- Sticky flags clear only on rst or init.

Decomposition:
- Shared package tinytpu_pkg holds:
  - result word width RW=2*D_W
  - FRAME_WORDS=N*N
  - collector state enum {IDLE, RECV, DONE}
- One natural sub-module: serial_word_deser (shift register plus bit counter, emits word plus word_strobe). The FSM, buffer, and stream port stay in result_collector.

Test Plan:
- Reset then full frame, D_W=8, N=2: stream words 0x0001, 0x1234, 0xBEEF, 0x8000 LSB first, 64 bits. Expected: out_valid rises 1 cycle after bit 63; out_ready=1 yields the same 4 words in order; frame_done=0 afterwards; no flags set.
- Backpressure: out_ready toggles 1,0,0,1. Expected: out_data holds each word unchanged while stalled, no word skipped or duplicated.
- Truncated frame: tx_ready drops after 20 bits. Expected: frame_err=1, out_valid never asserts, state returns to IDLE. A following good frame is collected correctly with frame_err still 1.
- Overrun: after a full frame with only 1 word drained, start a new frame of 0xAAAA x4. Expected: overrun=1, the stream then delivers four 0xAAAA words.
- Extra bits: tx_ready held 8 cycles past bit 63. Expected: the buffered frame is unchanged and frame_err=0.
- init and async reset mid-RECV:
  - init at bit 30: all outputs return to reset values the next cycle.
  - rst low at bit 30: all outputs return to reset values immediately.
  - In both cases a subsequent frame is received correctly.
